// File: rtl/inst_ram_loader_if.sv
// Interface bundling the loader's control, byte-stream and RAM write signals.
//   master : the host side (drives start/len_words/byte stream, observes status
//            and the RAM write port)
//   slave  : the loader itself
interface inst_ram_loader_if #(
  parameter int ADDR_W = 6
);
  logic              start;
  logic [ADDR_W:0]   len_words;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, len_words, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err
  );

  modport slave (
    input  start, len_words, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err
  );
endinterface

// File: rtl/inst_ram_loader.sv
// Instruction RAM loader: packs a big-endian byte stream into 32-bit words and
// writes them to consecutive instruction RAM addresses starting at 0. Holds the
// CPU in reset from power-up until a load completes and for every load.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - slave side of inst_ram_loader_if: start/len_words request, byte
//          stream (byte_in/byte_valid/byte_ready), RAM write port
//          (mem_we/mem_addr/mem_wdata), cpu_rst, busy, done/err pulses.
// All outputs are registered.
module inst_ram_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic             clk,
  input  logic             rst,
  inst_ram_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0]   MAX_LEN  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t            state_q,     nxt_state;
  logic [ADDR_W:0]   len_q,       nxt_len;
  logic [ADDR_W:0]   word_cnt_q,  nxt_word_cnt;
  logic [1:0]        byte_cnt_q,  nxt_byte_cnt;
  logic              ready_q,     nxt_ready;
  logic              we_q,        nxt_we;
  logic [ADDR_W-1:0] addr_q,      nxt_addr;
  logic [31:0]       wdata_q,     nxt_wdata;
  logic              cpu_rst_q,   nxt_cpu_rst;
  logic              busy_q,      nxt_busy;
  logic              done_q,      nxt_done;
  logic              err_q,       nxt_err;

  logic xfer;
  assign xfer = bus.byte_valid && ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= nxt_state;
      len_q      <= nxt_len;
      word_cnt_q <= nxt_word_cnt;
      byte_cnt_q <= nxt_byte_cnt;
      ready_q    <= nxt_ready;
      we_q       <= nxt_we;
      addr_q     <= nxt_addr;
      wdata_q    <= nxt_wdata;
      cpu_rst_q  <= nxt_cpu_rst;
      busy_q     <= nxt_busy;
      done_q     <= nxt_done;
      err_q      <= nxt_err;
    end
  end

  always_comb begin
    nxt_state    = state_q;
    nxt_len      = len_q;
    nxt_word_cnt = word_cnt_q;
    nxt_byte_cnt = byte_cnt_q;
    nxt_ready    = ready_q;
    nxt_addr     = addr_q;
    nxt_wdata    = wdata_q;
    nxt_cpu_rst  = cpu_rst_q;
    nxt_busy     = busy_q;
    nxt_we       = 1'b0;   // write, done and err are single-cycle pulses
    nxt_done     = 1'b0;
    nxt_err      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len_words == '0 || bus.len_words > MAX_LEN) begin
            nxt_err = 1'b1;
          end else begin
            nxt_len      = bus.len_words;
            nxt_word_cnt = '0;
            nxt_byte_cnt = '0;
            nxt_addr     = '0;
            nxt_cpu_rst  = 1'b1;
            nxt_busy     = 1'b1;
            nxt_ready    = 1'b1;
            nxt_state    = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (xfer) begin
          nxt_wdata    = {wdata_q[23:0], bus.byte_in};
          nxt_byte_cnt = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Word complete: drop ready and raise we together so the write
            // cycle sees stable addr/data and no byte can slip in.
            nxt_ready = 1'b0;
            nxt_we    = 1'b1;
            nxt_state = WRITE;
          end
        end
      end
      WRITE: begin
        nxt_word_cnt = word_cnt_q + CNT_ONE;
        if (word_cnt_q + CNT_ONE == len_q) begin
          nxt_done    = 1'b1;
          nxt_cpu_rst = 1'b0;
          nxt_busy    = 1'b0;
          nxt_state   = DONE;
        end else begin
          nxt_addr     = addr_q + ADDR_ONE;
          nxt_byte_cnt = '0;
          nxt_ready    = 1'b1;
          nxt_state    = COLLECT;
        end
      end
      DONE: begin
        nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign bus.byte_ready = ready_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.cpu_rst    = cpu_rst_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_inst_ram_loader.sv
module tb_inst_ram_loader;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_ram_loader_if #(.ADDR_W(ADDR_W)) bus ();

  inst_ram_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // write log and pulse counters, sampled on the falling edge
  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];
  int done_cnt = 0;
  int err_cnt  = 0;
  int rdy_in_wr = 0;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
    end
    if (bus.mem_we && bus.byte_ready) rdy_in_wr++;
    if (bus.done) done_cnt++;
    if (bus.err)  err_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [ADDR_W:0] len);
    bus.start     = 1'b1;
    bus.len_words = len;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      bus.byte_valid = 1'b0;
      tick();
    end
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    n = 0;
    while (!bus.byte_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8], gap);
  endtask

  task automatic wait_done;
    int n;
    bit hold;
    n = 0;
    hold = 1'b1;
    while (!bus.done && n < 20) begin
      if (!bus.cpu_rst) hold = 1'b0;
      tick();
      n++;
    end
    chk("done_seen",    32'(bus.done),    32'd1);
    chk("cpu_rst_held", 32'(hold),        32'd1);
    chk("done_cpu_rst", 32'(bus.cpu_rst), 32'd0);
    chk("done_busy",    32'(bus.busy),    32'd0);
    tick();
    chk("done_1cyc",    32'(bus.done),       32'd0);
    chk("idle_rdy",     32'(bus.byte_ready), 32'd0);
  endtask

  typedef struct {
    logic [ADDR_W:0] len;
    logic [7:0]      b0, b1, b2, b3;   // sent in this order
    bit              gap;
    bit              exp_err;
    bit              exp_cpu_rst;      // cpu_rst expected alongside err
    logic [31:0]     exp_wdata;
  } vec_t;

  vec_t v[5];
  int wb, db, eb;
  logic [31:0] w;
  int mism;

  initial begin
    v[0] = '{7'd0,   8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 32'h0};
    v[1] = '{7'd65,  8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 32'h0};
    v[2] = '{7'd1,   8'h00, 8'h22, 8'h08, 8'h20, 1'b0, 1'b0, 1'b0, 32'h00220820};
    v[3] = '{7'd127, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0};
    v[4] = '{7'd1,   8'hDE, 8'hAD, 8'hBE, 8'hEF, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};

    bus.start = 1'b0;
    bus.len_words = '0;
    bus.byte_in = '0;
    bus.byte_valid = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_rdy",     32'(bus.byte_ready), 32'd0);
    chk("rst_we",      32'(bus.mem_we),     32'd0);
    chk("rst_addr",    32'(bus.mem_addr),   32'd0);
    chk("rst_wdata",   bus.mem_wdata,       32'd0);
    chk("rst_cpu_rst", 32'(bus.cpu_rst),    32'd1);
    chk("rst_busy",    32'(bus.busy),       32'd0);
    chk("rst_done",    32'(bus.done),       32'd0);
    chk("rst_err",     32'(bus.err),        32'd0);
    rst = 1'b0;
    tick();

    // table: single-word loads and rejected lengths
    for (int i = 0; i < 5; i++) begin
      wb = wr_addr.size();
      do_start(v[i].len);
      if (v[i].exp_err) begin
        chk("err_pulse",   32'(bus.err),        32'd1);
        chk("err_busy",    32'(bus.busy),       32'd0);
        chk("err_rdy",     32'(bus.byte_ready), 32'd0);
        chk("err_cpu_rst", 32'(bus.cpu_rst),    32'(v[i].exp_cpu_rst));
        tick();
        chk("err_clear",   32'(bus.err),        32'd0);
        repeat (3) tick();
        chk("err_no_we",   32'(wr_addr.size() - wb), 32'd0);
        chk("err_rdy2",    32'(bus.byte_ready), 32'd0);
      end else begin
        chk("ld_busy",    32'(bus.busy),       32'd1);
        chk("ld_cpu_rst", 32'(bus.cpu_rst),    32'd1);
        chk("ld_rdy",     32'(bus.byte_ready), 32'd1);
        send_byte(v[i].b0, v[i].gap);
        send_byte(v[i].b1, v[i].gap);
        send_byte(v[i].b2, v[i].gap);
        send_byte(v[i].b3, v[i].gap);
        chk("ld_we_now",  32'(bus.mem_we),     32'd1);
        wait_done();
        chk("ld_nwr",     32'(wr_addr.size() - wb), 32'd1);
        if (wr_addr.size() > wb) begin
          chk("ld_addr",  32'(wr_addr[wb]), 32'd0);
          chk("ld_wdata", wr_data[wb],      v[i].exp_wdata);
        end
      end
    end

    // 3 words with byte_valid toggling every other cycle
    wb = wr_addr.size();
    do_start(7'd3);
    chk("l3_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    send_word(32'h11223344, 1'b1);
    send_word(32'h55667788, 1'b1);
    send_word(32'h99AABBCC, 1'b1);
    wait_done();
    chk("l3_nwr", 32'(wr_addr.size() - wb), 32'd3);
    if (wr_addr.size() - wb == 3) begin
      chk("l3_a0", 32'(wr_addr[wb]),   32'd0); chk("l3_d0", wr_data[wb],   32'h11223344);
      chk("l3_a1", 32'(wr_addr[wb+1]), 32'd1); chk("l3_d1", wr_data[wb+1], 32'h55667788);
      chk("l3_a2", 32'(wr_addr[wb+2]), 32'd2); chk("l3_d2", wr_data[wb+2], 32'h99AABBCC);
    end

    // full-depth load: word i = 0xC0DE0000 + i
    wb = wr_addr.size();
    db = done_cnt;
    do_start(7'd64);
    for (int i = 0; i < 64; i++) send_word(32'hC0DE0000 + 32'(i), 1'b0);
    wait_done();
    chk("l64_nwr",  32'(wr_addr.size() - wb), 32'd64);
    chk("l64_done", 32'(done_cnt - db),       32'd1);
    mism = 0;
    if (wr_addr.size() - wb == 64) begin
      for (int i = 0; i < 64; i++)
        if (wr_addr[wb+i] !== ADDR_W'(i) || wr_data[wb+i] !== 32'hC0DE0000 + 32'(i)) mism++;
      chk("l64_last_addr", 32'(wr_addr[wb+63]), 32'd63);
      chk("l64_last_data", wr_data[wb+63],      32'hC0DE003F);
    end
    chk("l64_mism", 32'(mism), 32'd0);

    // reset mid-load after 2 words + 2 bytes
    wb = wr_addr.size();
    do_start(7'd3);
    send_word(32'h01020304, 1'b0);
    send_word(32'h05060708, 1'b0);
    send_byte(8'h09, 1'b0);
    send_byte(8'h0A, 1'b0);
    rst = 1'b1;
    bus.byte_in = 8'h0B;
    bus.byte_valid = 1'b1;
    tick();
    chk("mr_rdy",     32'(bus.byte_ready), 32'd0);
    chk("mr_we",      32'(bus.mem_we),     32'd0);
    chk("mr_addr",    32'(bus.mem_addr),   32'd0);
    chk("mr_wdata",   bus.mem_wdata,       32'd0);
    chk("mr_cpu_rst", 32'(bus.cpu_rst),    32'd1);
    chk("mr_busy",    32'(bus.busy),       32'd0);
    chk("mr_done",    32'(bus.done),       32'd0);
    rst = 1'b0;
    repeat (4) tick();
    chk("mr_rdy_hold", 32'(bus.byte_ready),    32'd0);
    chk("mr_nwr",      32'(wr_addr.size() - wb), 32'd2);
    bus.byte_valid = 1'b0;
    wb = wr_addr.size();
    do_start(7'd1);
    send_word(32'hA5A50001, 1'b0);
    wait_done();
    chk("mr_re_nwr", 32'(wr_addr.size() - wb), 32'd1);
    if (wr_addr.size() > wb) begin
      chk("mr_re_addr", 32'(wr_addr[wb]), 32'd0);
      chk("mr_re_data", wr_data[wb],      32'hA5A50001);
    end

    // start while busy is ignored
    wb = wr_addr.size();
    eb = err_cnt;
    db = done_cnt;
    do_start(7'd2);
    send_byte(8'h12, 1'b0);
    do_start(7'd1);
    chk("sb_no_err", 32'(bus.err),  32'd0);
    chk("sb_busy",   32'(bus.busy), 32'd1);
    do_start(7'd0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h78, 1'b0);
    send_word(32'h9ABCDEF0, 1'b0);
    wait_done();
    chk("sb_nwr",   32'(wr_addr.size() - wb), 32'd2);
    chk("sb_errs",  32'(err_cnt - eb),        32'd0);
    chk("sb_dones", 32'(done_cnt - db),       32'd1);
    if (wr_addr.size() - wb == 2) begin
      chk("sb_d0", wr_data[wb],   32'h12345678);
      chk("sb_d1", wr_data[wb+1], 32'h9ABCDEF0);
      chk("sb_a1", 32'(wr_addr[wb+1]), 32'd1);
    end

    chk("rdy_in_write", 32'(rdy_in_wr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
